// File: rtl/mmio_port_unit.sv
// mmio_port_unit
//
// Memory-mapped I/O stage placed directly after the single-cycle MIPS
// datapath. The ALU result is used as the data address and register-file
// read data 2 is used as the store data. The block owns one 32-bit output
// port and one IN_WIDTH-bit input port. The input port is synchronized, and
// its edges are captured into write-1-to-clear status flags. The flags drive
// a maskable interrupt line.
//
// Build option: define MMIO_ANY_EDGE_EN to capture both rising and falling
// input transitions. With it undefined, only rising edges are captured.
//
// Ports:
//   clk        in   1         processor clock, all state on rising edge
//   reset      in   1         synchronous active-high reset
//   Address    in   32        byte address (ALU result)
//   WriteData  in   32        store data
//   MemWrite   in   1         store strobe, sampled at the clk rising edge
//   MemRead    in   1         load strobe, gates ReadData
//   PortIn     in   IN_WIDTH  asynchronous external input pins
//   ReadData   out  32        load data, combinational
//   Hit        out  1         Address decodes into this block, combinational
//   PortOut    out  32        registered output port
//   IRQ        out  1         registered interrupt request
//
// Access protocol: there is no handshake and the block never stalls.
// A load completes in the cycle where MemRead & Hit, with ReadData valid
// combinationally in that same cycle. A store commits at the rising edge
// where MemWrite & Hit. If a load and a store target the same register in
// one cycle, the load returns the value from before the store.
//
// Register map (word offsets from BASE_ADDR):
//   0x00 OUT   RW   drives PortOut
//   0x04 IN    RO   synchronized input, zero-extended
//   0x08 EDGE  W1C  sticky edge flags
//   0x0C MASK  RW   interrupt enables, low IN_WIDTH bits only
//   0x10-0x1C       reserved, read 0, writes ignored
module mmio_port_unit #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                Hit,
  output logic [31:0]         PortOut,
  output logic                IRQ
);

  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_EDGE = 3'd2;
  localparam logic [2:0] OFF_MASK = 3'd3;

  logic [31:0]         r_out;
  logic [IN_WIDTH-1:0] r_sync1;
  logic [IN_WIDTH-1:0] r_sync2;
  logic [IN_WIDTH-1:0] r_prev;
  logic [IN_WIDTH-1:0] r_edge;
  logic [IN_WIDTH-1:0] r_mask;
  logic                r_irq;

  logic                w_hit;
  logic [2:0]          w_offset;
  logic                w_wr_out;
  logic                w_wr_edge;
  logic                w_wr_mask;
  logic [IN_WIDTH-1:0] w_clr;
  logic [IN_WIDTH-1:0] w_edge_term;
  logic [IN_WIDTH-1:0] w_edge_next;
  logic [31:0]         w_in_ext;
  logic [31:0]         w_edge_ext;
  logic [31:0]         w_mask_ext;
  logic [31:0]         w_rdata;

  // Only word-aligned addresses inside the 32-byte window decode.
  assign w_hit    = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
  assign w_offset = Address[4:2];

  assign w_wr_out  = MemWrite && w_hit && (w_offset == OFF_OUT);
  assign w_wr_edge = MemWrite && w_hit && (w_offset == OFF_EDGE);
  assign w_wr_mask = MemWrite && w_hit && (w_offset == OFF_MASK);

  always_comb begin
    w_clr = '0;
    if (w_wr_edge) begin
      w_clr = WriteData[IN_WIDTH-1:0];
    end
`ifdef MMIO_ANY_EDGE_EN
    w_edge_term = r_sync2 ^ r_prev;
`else
    w_edge_term = r_sync2 & ~r_prev;
`endif
    // The new edge term is ORed in after the clear, so a fresh edge wins
    // over a same-cycle W1C on that bit.
    w_edge_next = (r_edge & ~w_clr) | w_edge_term;
  end

  // Zero-extend the narrow registers for the read mux. This form is also
  // legal when IN_WIDTH is 32.
  always_comb begin
    w_in_ext   = '0;
    w_edge_ext = '0;
    w_mask_ext = '0;
    w_in_ext[IN_WIDTH-1:0]   = r_sync2;
    w_edge_ext[IN_WIDTH-1:0] = r_edge;
    w_mask_ext[IN_WIDTH-1:0] = r_mask;
  end

  always_comb begin
    w_rdata = '0;
    if (MemRead && w_hit) begin
      case (w_offset)
        OFF_OUT:  w_rdata = r_out;
        OFF_IN:   w_rdata = w_in_ext;
        OFF_EDGE: w_rdata = w_edge_ext;
        OFF_MASK: w_rdata = w_mask_ext;
        default:  w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_edge  <= '0;
      r_mask  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= w_edge_next;
      if (w_wr_out) begin
        r_out <= WriteData;
      end
      if (w_wr_mask) begin
        r_mask <= WriteData[IN_WIDTH-1:0];
      end
      // Computed from the registered flags and mask, so IRQ follows any
      // change to EDGE or MASK by one edge.
      r_irq <= |(r_edge & r_mask);
    end
  end

  assign ReadData = w_rdata;
  assign Hit      = w_hit;
  assign PortOut  = r_out;
  assign IRQ      = r_irq;

endmodule

// File: tb/tb_mmio_port_unit.sv
module tb_mmio_port_unit;

  localparam logic [31:0] A_OUT  = 32'hFFFF_0000;
  localparam logic [31:0] A_IN   = 32'hFFFF_0004;
  localparam logic [31:0] A_EDGE = 32'hFFFF_0008;
  localparam logic [31:0] A_MASK = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
  logic        IRQ;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  mmio_port_unit dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PortIn    (PortIn),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortOut   (PortOut),
    .IRQ       (IRQ)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
    WriteData = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Address = addr;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    Address   = 32'h0;
    WriteData = 32'h0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PortIn    = 8'h00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_irq", {31'b0, IRQ}, 32'h0);
    rd_chk("rst_in", A_IN, 32'h0);
    rd_chk("rst_edge", A_EDGE, 32'h0);
    rd_chk("rst_mask", A_MASK, 32'h0);

    // OUT write, then reset overriding a simultaneous write
    wr(A_OUT, 32'hDEAD_BEEF);
    chk("out_wr_port", PortOut, 32'hDEAD_BEEF);
    rd_chk("out_wr_read", A_OUT, 32'hDEAD_BEEF);
    reset = 1'b1;
    wr(A_OUT, 32'h1234_5678);
    reset = 1'b0;
    chk("rst2_portout", PortOut, 32'h0);
    chk("rst2_irq", {31'b0, IRQ}, 32'h0);

    // PortIn 00 -> 05: IN after k+1, EDGE at k+2, IRQ stays 0 with MASK 0
    PortIn = 8'h05;
    tick(); // edge k
    rd_chk("in_k", A_IN, 32'h0);
    tick(); // edge k+1
    rd_chk("in_k1", A_IN, 32'h0000_0005);
    rd_chk("edge_k1", A_EDGE, 32'h0);
    tick(); // edge k+2
    rd_chk("edge_k2", A_EDGE, 32'h0000_0005);
    chk("irq_k2", {31'b0, IRQ}, 32'h0);
    tick(); // edge k+3
    chk("irq_k3_masked", {31'b0, IRQ}, 32'h0);
    rd_chk("edge_no_clr_on_read", A_EDGE, 32'h0000_0005);

    // MASK=01 -> IRQ one edge after the write
    wr(A_MASK, 32'h0000_0001);
    chk("irq_at_mask_wr", {31'b0, IRQ}, 32'h0);
    rd_chk("mask_read", A_MASK, 32'h0000_0001);
    tick();
    chk("irq_set", {31'b0, IRQ}, 32'h1);

    // W1C on EDGE[0] -> EDGE=04, IRQ drops one edge later
    wr(A_EDGE, 32'h0000_0001);
    rd_chk("edge_w1c", A_EDGE, 32'h0000_0004);
    chk("irq_at_clr_wr", {31'b0, IRQ}, 32'h1);
    tick();
    chk("irq_cleared", {31'b0, IRQ}, 32'h0);

    // MASK upper bits are not stored
    wr(A_MASK, 32'hABCD_0001);
    rd_chk("mask_upper", A_MASK, 32'h0000_0001);

    // PortIn 05 -> 04: falling edge on bit 0
    PortIn = 8'h04;
    tick(); // k
    tick(); // k+1
    tick(); // k+2
`ifdef MMIO_ANY_EDGE_EN
    rd_chk("fall_edge", A_EDGE, 32'h0000_0005);
`else
    rd_chk("fall_edge", A_EDGE, 32'h0000_0004);
`endif
    tick();
    wr(A_EDGE, 32'h0000_0005);
    rd_chk("edge_clr_all", A_EDGE, 32'h0);
    tick();
    chk("irq_after_clr_all", {31'b0, IRQ}, 32'h0);

    // New rise on bit 0 coincides with a W1C of bit 0: set wins
    PortIn = 8'h05;
    tick(); // k
    tick(); // k+1
    wr(A_EDGE, 32'h0000_0001); // commits at k+2 with the rise term active
    rd_chk("set_wins", A_EDGE, 32'h0000_0001);
    tick();
    chk("set_wins_irq", {31'b0, IRQ}, 32'h1);

    // Decode boundaries
    wr(A_OUT, 32'h1111_1111);
    Address = 32'hFFFF_0002;
    #1;
    chk("hit_misaligned", {31'b0, Hit}, 32'h0);
    rd_chk("rd_misaligned", 32'hFFFF_0002, 32'h0);
    Address = 32'hFFFF_0014;
    #1;
    chk("hit_reserved", {31'b0, Hit}, 32'h1);
    rd_chk("rd_reserved", 32'hFFFF_0014, 32'h0);
    Address = 32'h0000_0004;
    #1;
    chk("hit_outside", {31'b0, Hit}, 32'h0);
    rd_chk("rd_outside", 32'h0000_0004, 32'h0);
    wr(32'hFFFF_0002, 32'h0);
    wr(32'hFFFF_0014, 32'h0);
    wr(32'h0000_0004, 32'h0);
    wr(32'h0000_0000, 32'h0);
    wr(32'h0000_0008, 32'hFFFF_FFFF);
    wr(32'hFFFF_000E, 32'h0);
    wr(A_IN, 32'h0000_00FF);
    chk("nowr_portout", PortOut, 32'h1111_1111);
    rd_chk("nowr_mask", A_MASK, 32'h0000_0001);
    rd_chk("nowr_edge", A_EDGE, 32'h0000_0001);
    rd_chk("nowr_in", A_IN, 32'h0000_0005);

    // Load with MemRead low returns 0 even on a hit
    Address = A_OUT;
    MemRead = 1'b0;
    #1;
    chk("rd_gated", ReadData, 32'h0);

    // Simultaneous read and write of OUT: read shows the old value
    Address   = A_OUT;
    WriteData = 32'h2222_2222;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    #1;
    chk("rw_pre", ReadData, 32'h1111_1111);
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    chk("rw_post", PortOut, 32'h2222_2222);

    // PortIn held high across reset release reports an edge
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rel_portout", PortOut, 32'h0);
    rd_chk("rel_edge0", A_EDGE, 32'h0);
    tick(); // k
    rd_chk("rel_in_k", A_IN, 32'h0);
    tick(); // k+1
    rd_chk("rel_in_k1", A_IN, 32'h0000_0005);
    rd_chk("rel_edge_k1", A_EDGE, 32'h0);
    tick(); // k+2
    rd_chk("rel_edge_k2", A_EDGE, 32'h0000_0005);
    wr(A_MASK, 32'h0000_0004);
    tick();
    chk("rel_irq", {31'b0, IRQ}, 32'h1);

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
